// File: rtl/jtframe_st_arb.sv
// Two-port round-robin arbiter for the registered status read bus. It holds the
// granted address for LAT cycles and returns the byte with a one-cycle ack.
module jtframe_st_arb #(
  parameter int unsigned LAT      = 2,
  parameter logic [7:0]  ADDR_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_req,
  input  logic [7:0] a_addr,
  output logic       a_ack,
  output logic [7:0] a_dout,
  input  logic       b_req,
  input  logic [7:0] b_addr,
  output logic       b_ack,
  output logic [7:0] b_dout,
  output logic [7:0] st_addr,
  input  logic [7:0] st_din,
  output logic       busy
);

  localparam logic [2:0] CntInit = 3'(LAT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;       // 1 = port B owns the transaction
  logic       prefer_b_q, prefer_b_d; // set once A has been served last
  logic [7:0] st_addr_q, st_addr_d;
  logic [7:0] a_dout_q, a_dout_d;
  logic [7:0] b_dout_q, b_dout_d;
  logic       a_ack_q, a_ack_d;
  logic       b_ack_q, b_ack_d;
  logic       busy_q, busy_d;
  logic       win_b;

  assign win_b = b_req & (~a_req | prefer_b_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    prefer_b_d = prefer_b_q;
    st_addr_d  = st_addr_q;
    a_dout_d   = a_dout_q;
    b_dout_d   = b_dout_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    busy_d     = busy_q;
    unique case (state_q)
      StIdle: begin
        if (a_req | b_req) begin
          owner_d   = win_b;
          st_addr_d = win_b ? b_addr : a_addr;
          cnt_d     = CntInit;
          busy_d    = 1'b1;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          if (owner_q) begin
            b_ack_d  = 1'b1;
            b_dout_d = st_din;
          end else begin
            a_ack_d  = 1'b1;
            a_dout_d = st_din;
          end
          prefer_b_d = ~owner_q;
          state_d    = StAck;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StAck: begin
        // No grant here so the requester has a cycle to drop req.
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      owner_q    <= 1'b0;
      prefer_b_q <= 1'b0;
      st_addr_q  <= ADDR_RST;
      a_dout_q   <= 8'h00;
      b_dout_q   <= 8'h00;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      prefer_b_q <= prefer_b_d;
      st_addr_q  <= st_addr_d;
      a_dout_q   <= a_dout_d;
      b_dout_q   <= b_dout_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign st_addr = st_addr_q;
  assign a_dout  = a_dout_q;
  assign b_dout  = b_dout_q;
  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_jtframe_st_arb.sv
// Bench for jtframe_st_arb: directed and random traffic against a transaction-level
// model that predicts grant/ack cycles and returned data from cycle arithmetic.
module tb_jtframe_st_arb;

  localparam int unsigned LAT      = 2;
  localparam logic [7:0]  ADDR_RST = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req, b_req, a_ack, b_ack, busy;
  logic [7:0] a_addr, b_addr, a_dout, b_dout, st_addr;
  logic [7:0] st_din = 8'h00;

  jtframe_st_arb #(.LAT(LAT), .ADDR_RST(ADDR_RST)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_req  (a_req),
    .a_addr (a_addr),
    .a_ack  (a_ack),
    .a_dout (a_dout),
    .b_req  (b_req),
    .b_addr (b_addr),
    .b_ack  (b_ack),
    .b_dout (b_dout),
    .st_addr(st_addr),
    .st_din (st_din),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Status block: one register stage behind st_addr, giving LAT=2 overall.
  always @(posedge clk) st_din <= st_addr ^ 8'h5A;

  int n_chk = 0;
  int n_fail = 0;

  // Transaction-level model.
  int         cyc = 0;
  int         grant_cyc;
  bit         in_txn, own_b, prefer_b;
  logic [7:0] m_addr, m_st_addr, m_a_dout, m_b_dout;
  bit         m_a_ack, m_b_ack;

  bit a_hold, b_hold, b_wait;
  int b_rise;
  bit ack_log[$];
  int ack_cyc[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    in_txn = 0; prefer_b = 0; m_st_addr = ADDR_RST;
    m_a_dout = 8'h00; m_b_dout = 8'h00; m_a_ack = 0; m_b_ack = 0;
  endtask

  task automatic model_edge();
    cyc++;
    m_a_ack = 0;
    m_b_ack = 0;
    if (!rst_n) begin
      model_reset();
    end else if (in_txn) begin
      if (cyc == grant_cyc + int'(LAT)) begin
        if (own_b) begin m_b_ack = 1; m_b_dout = m_addr ^ 8'h5A; end
        else       begin m_a_ack = 1; m_a_dout = m_addr ^ 8'h5A; end
        prefer_b = !own_b;
      end else if (cyc == grant_cyc + int'(LAT) + 1) begin
        in_txn = 0;
      end
    end else if (a_req || b_req) begin
      own_b     = b_req && (!a_req || prefer_b);
      m_addr    = own_b ? b_addr : a_addr;
      m_st_addr = m_addr;
      grant_cyc = cyc;
      in_txn    = 1;
    end
  endtask

  task automatic check_outputs();
    chk("a_ack", 8'(a_ack), 8'(m_a_ack));
    chk("b_ack", 8'(b_ack), 8'(m_b_ack));
    chk("a_dout", a_dout, m_a_dout);
    chk("b_dout", b_dout, m_b_dout);
    chk("st_addr", st_addr, m_st_addr);
    chk("busy", 8'(busy), 8'(in_txn));
    chk("ack_excl", 8'(a_ack & b_ack), 8'h00);
  endtask

  // One clock: model update at the edge, check at the falling edge, then requester protocol.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    if (m_a_ack) begin
      ack_log.push_back(1'b0); ack_cyc.push_back(cyc);
      if (!a_hold) a_req = 0;
    end
    if (m_b_ack) begin
      ack_log.push_back(1'b1); ack_cyc.push_back(cyc);
      if (b_wait) begin
        chk("b_starve", 8'(cyc - b_rise <= 2 * int'(LAT + 2)), 8'h01);
        b_wait = 0;
      end
      if (!b_hold) b_req = 0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (in_txn || a_req || b_req); i++) step();
    step();
  endtask

  initial begin
    int start;
    int n_b;
    a_req = 0; b_req = 0; a_addr = 8'h00; b_addr = 8'h00;
    a_hold = 0; b_hold = 0; b_wait = 0;
    model_reset();

    // Reset values
    repeat (2) step();
    rst_n = 1;
    step();

    // Single read on A
    ack_log.delete(); ack_cyc.delete();
    start = cyc;
    a_addr = 8'h41; a_req = 1;
    repeat (6) step();
    chk("single_a_dout", a_dout, 8'h1B);
    chk("single_st_addr", st_addr, 8'h41);
    chk("single_n_ack", 8'(ack_cyc.size()), 8'd1);
    chk("single_lat", (ack_cyc.size() > 0) ? 8'(ack_cyc[0] - start) : 8'hFF, 8'(LAT + 1));

    // Contention from reset release: A first, then alternate every LAT+2 cycles
    rst_n = 0;
    repeat (2) step();
    a_addr = 8'h40; b_addr = 8'h80; a_req = 1; b_req = 1; a_hold = 1; b_hold = 1;
    ack_log.delete(); ack_cyc.delete();
    rst_n = 1;
    repeat (17) step();
    chk("cont_n_ack", 8'(ack_log.size() >= 4), 8'h01);
    for (int i = 0; i < ack_log.size(); i++) begin
      chk("cont_alt", 8'(ack_log[i]), 8'(i % 2));
      if (i > 0) chk("cont_gap", 8'(ack_cyc[i] - ack_cyc[i-1]), 8'(LAT + 2));
    end
    chk("cont_a_dout", a_dout, 8'h1A);
    chk("cont_b_dout", b_dout, 8'hDA);
    a_hold = 0; b_hold = 0;
    drain();

    // B request withdrawn after one cycle still completes once
    ack_log.delete(); ack_cyc.delete();
    b_addr = 8'h77; b_req = 1;
    step();
    b_req = 0;
    repeat (8) step();
    n_b = 0;
    foreach (ack_log[i]) if (ack_log[i]) n_b++;
    chk("wd_n_ack", 8'(n_b), 8'd1);
    chk("wd_b_dout", b_dout, 8'h2D);
    chk("wd_busy", 8'(busy), 8'h00);

    // A held permanently, B pulsed randomly; addresses wobble mid-transaction
    a_hold = 1; a_addr = 8'($urandom); a_req = 1;
    for (int i = 0; i < 400; i++) begin
      if (!b_req && $urandom_range(0, 3) == 0) begin
        b_req = 1; b_addr = 8'($urandom); b_rise = cyc; b_wait = 1;
      end
      if (in_txn && cyc < grant_cyc + int'(LAT)) begin
        if (own_b) b_addr = 8'($urandom);
        else       a_addr = 8'($urandom);
      end
      step();
    end
    a_hold = 0;
    drain();
    b_wait = 0;

    // Asynchronous reset while waiting on the status block
    a_addr = 8'h33; a_req = 1;
    step();
    step();
    chk("mid_in_wait", 8'(in_txn && cyc == grant_cyc + 1), 8'h01);
    #2 rst_n = 0;
    #1 model_reset();
    check_outputs();
    repeat (2) step();
    rst_n = 1;
    repeat (6) step();
    chk("mid_a_dout", a_dout, 8'h69);
    chk("mid_busy", 8'(busy), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
